// File: rtl/eight_data_compress_unit.sv
// Two-stage compressor: eight 32-bit words are size-classified and packed densely into a 256-bit payload.
// Optional build macro EIGHT_COMPRESS_BYTE_CLASS_EN enables the 1-byte class (tag 01).
module eight_data_compress_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         wrtEn,
  input  logic [255:0] dataIn,
  output logic [255:0] dataOut,
  output logic [15:0]  tagOut,
  output logic [7:0]   lenOut
);

  localparam int NWORDS = 8;
  localparam int DATA_W = 32;

  function automatic logic [1:0] classify(input logic [DATA_W-1:0] w);
    logic [1:0] t;
    if (w == '0)
      t = 2'b00;
`ifdef EIGHT_COMPRESS_BYTE_CLASS_EN
    else if (w[31:8] == '0)
      t = 2'b01;
`endif
    else if (w[31:16] == '0)
      t = 2'b10;
    else
      t = 2'b11;
    return t;
  endfunction

  function automatic logic [2:0] byteCount(input logic [1:0] t);
    logic [2:0] n;
    case (t)
      2'b00:   n = 3'd0;
      2'b01:   n = 3'd1;
      2'b10:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Masking keeps the packer a plain OR even if a class ever keeps fewer bytes than the word has.
  function automatic logic [DATA_W-1:0] keepBytes(input logic [DATA_W-1:0] w, input logic [1:0] t);
    logic [DATA_W-1:0] k;
    case (t)
      2'b00:   k = '0;
      2'b01:   k = {24'b0, w[7:0]};
      2'b10:   k = {16'b0, w[15:0]};
      default: k = w;
    endcase
    return k;
  endfunction

  logic [DATA_W-1:0] keepC [NWORDS];
  logic [5:0]        offC  [NWORDS];
  logic [15:0]       tagC;
  logic [5:0]        lenC;

  always_comb begin
    logic [5:0] run;
    logic [1:0] t;
    run  = '0;
    tagC = '0;
    for (int i = 0; i < NWORDS; i++) begin
      t              = classify(dataIn[DATA_W*i +: DATA_W]);
      tagC[2*i +: 2] = t;
      keepC[i]       = keepBytes(dataIn[DATA_W*i +: DATA_W], t);
      offC[i]        = run;
      run            = run + {3'b000, byteCount(t)};
    end
    lenC = run;
  end

  // Stage 1: capture kept words, tags and prefix byte offsets
  logic [DATA_W-1:0] word_p1 [NWORDS];
  logic [5:0]        off_p1  [NWORDS];
  logic [15:0]       tag_p1;
  logic [5:0]        len_p1;
  logic              vld_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
      len_p1 <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        word_p1[i] <= '0;
        off_p1[i]  <= '0;
      end
    end else begin
      vld_p1 <= wrtEn;
      if (wrtEn) begin
        tag_p1 <= tagC;
        len_p1 <= lenC;
        for (int i = 0; i < NWORDS; i++) begin
          word_p1[i] <= keepC[i];
          off_p1[i]  <= offC[i];
        end
      end
    end
  end

  logic [255:0] packC;

  always_comb begin
    packC = '0;
    for (int i = 0; i < NWORDS; i++)
      packC = packC | (256'(word_p1[i]) << {off_p1[i], 3'b000});
  end

  // Stage 2: output registers, updated only by a valid stage-1 block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut <= '0;
      tagOut  <= '0;
      lenOut  <= '0;
    end else if (vld_p1) begin
      dataOut <= packC;
      tagOut  <= tag_p1;
      lenOut  <= {2'b00, len_p1};
    end
  end

endmodule

// File: tb/tb_eight_data_compress_unit.sv
// Scoreboard bench for eight_data_compress_unit: directed spec vectors plus random blocks against a byte-list model.
module tb_eight_data_compress_unit;

`ifdef EIGHT_COMPRESS_BYTE_CLASS_EN
  localparam bit BYTEMODE = 1'b1;
`else
  localparam bit BYTEMODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         wrtEn;
  logic [255:0] dataIn;
  logic [255:0] dataOut;
  logic [15:0]  tagOut;
  logic [7:0]   lenOut;

  eight_data_compress_unit dut (
    .clk    (clk),
    .reset  (reset),
    .wrtEn  (wrtEn),
    .dataIn (dataIn),
    .dataOut(dataOut),
    .tagOut (tagOut),
    .lenOut (lenOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [15:0]  t;
    logic [7:0]   l;
    int           ready;
  } exp_t;

  exp_t sbQ[$];
  exp_t cur;
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: retire expectations once their output edge has passed, then compare every cycle
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].ready <= cyc) cur = sbQ.pop_front();
    check("dataOut", dataOut, cur.d);
    check("tagOut", 256'(tagOut), 256'(cur.t));
    check("lenOut", 256'(lenOut), 256'(cur.l));
  end

  // Reference: list the kept bytes word by word, then lay them out from byte 0
  function automatic exp_t model(input logic [255:0] din);
    exp_t e;
    logic [7:0] bytesQ[$];
    logic [31:0] w;
    int n;
    logic [1:0] tg;
    e.t = '0;
    for (int i = 0; i < 8; i++) begin
      w = din[32*i +: 32];
      if (w == 0) begin n = 0; tg = 2'b00; end
      else if (BYTEMODE && w < 32'h100) begin n = 1; tg = 2'b01; end
      else if (w < 32'h10000) begin n = 2; tg = 2'b10; end
      else begin n = 4; tg = 2'b11; end
      for (int b = 0; b < n; b++) bytesQ.push_back(w[8*b +: 8]);
      e.t[2*i +: 2] = tg;
    end
    e.d = '0;
    for (int k = 0; k < bytesQ.size(); k++) e.d[8*k +: 8] = bytesQ[k];
    e.l = 8'(bytesQ.size());
    e.ready = 0;
    return e;
  endfunction

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = '0;
      1: w = {24'b0, 8'($urandom_range(1, 255))};
      2: w = {16'b0, 16'($urandom_range(256, 65535))};
      default: w = {16'($urandom_range(1, 65535)), 16'($urandom)};
    endcase
    return w;
  endfunction

  function automatic logic [255:0] randBlock();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[32*i +: 32] = randWord();
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [255:0] din, input logic [255:0] d, input logic [15:0] t, input logic [7:0] l);
    exp_t e;
    wrtEn  = 1'b1;
    dataIn = din;
    e.d = d; e.t = t; e.l = l; e.ready = cyc + 2;
    sbQ.push_back(e);
    step();
    wrtEn = 1'b0;
  endtask

  task automatic issueModel(input logic [255:0] din);
    exp_t e;
    e = model(din);
    issue(din, e.d, e.t, e.l);
  endtask

  logic [255:0] allFE, mixed, mixedD;
  logic [15:0]  mixedT;
  logic [7:0]   mixedL;

  initial begin
    cur.d = '0; cur.t = '0; cur.l = '0; cur.ready = 0;
    allFE = {8{32'hFEDCBA98}};
    mixed = 256'hFEDCBA98_00007654_00000032_1FEDCBA9_00008765_00000043_00000000_00000021;
    if (BYTEMODE) begin
      mixedD = 256'hFEDCBA98_7654_32_1FEDCBA9_8765_43_21;
      mixedT = 16'hE791;
      mixedL = 8'h0F;
    end else begin
      mixedD = 256'hFEDCBA98_7654_0032_1FEDCBA9_8765_0043_0021;
      mixedT = 16'hEBA2;
      mixedL = 8'h12;
    end

    reset  = 1'b0;
    wrtEn  = 1'b1;
    dataIn = allFE;
    repeat (2) step();
    wrtEn = 1'b0;
    reset = 1'b1;
    step();

    issue(allFE, allFE, 16'hFFFF, 8'h20);
    for (int i = 0; i < 5; i++) begin
      dataIn = randBlock();
      step();
    end
    issue(mixed, mixedD, mixedT, mixedL);
    step();
    issue('0, '0, '0, '0);
    step();
    issueModel(mixed);
    issueModel(allFE);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) issueModel(randBlock());
      else begin
        dataIn = randBlock();
        step();
      end
    end
    repeat (3) step();

    // Reset with one block on the outputs and another in flight
    issue(mixed, mixedD, mixedT, mixedL);
    issue(allFE, allFE, 16'hFFFF, 8'h20);
    reset  = 1'b0;
    wrtEn  = 1'b1;
    dataIn = randBlock();
    #1;
    check("rst_dataOut", dataOut, '0);
    check("rst_tagOut", 256'(tagOut), '0);
    check("rst_lenOut", 256'(lenOut), '0);
    sbQ.delete();
    cur.d = '0; cur.t = '0; cur.l = '0;
    repeat (2) step();
    wrtEn = 1'b0;
    reset = 1'b1;
    repeat (4) step();

    issueModel(randBlock());
    issueModel(randBlock());
    repeat (4) step();

    nChecks++;
    if (sbQ.size() == 0) nPass++;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", sbQ.size());

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
